// File: rtl/l2_arbiter_if.sv
// Bundle of both L1 miss ports and the l2cmem port shared through l2_arbiter.
// slave = arbiter side, master = L1/L2 side (testbench or system wrapper).
interface l2_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
);
   // Handshake: an L1 raises read/write (level) with address/wdata stable and
   // holds it until its resp pulse; resp lasts exactly one cycle and qualifies
   // rdata. l2cmem_read/write are held until the one-cycle l2cmem_resp.
   logic                  icache_read;
   logic [ADDR_WIDTH-1:0] icache_addr;
   logic                  icache_resp;
   logic [LINE_WIDTH-1:0] icache_rdata;

   logic                  dcache_read;
   logic                  dcache_write;
   logic [ADDR_WIDTH-1:0] dcache_addr;
   logic [LINE_WIDTH-1:0] dcache_wdata;
   logic                  dcache_resp;
   logic [LINE_WIDTH-1:0] dcache_rdata;

   logic                  l2cmem_read;
   logic                  l2cmem_write;
   logic [ADDR_WIDTH-1:0] l2cmem_address;
   logic [LINE_WIDTH-1:0] l2cmem_wdata;
   logic                  l2cmem_resp;
   logic [LINE_WIDTH-1:0] l2cmem_rdata;

   modport slave (
      input  icache_read, icache_addr,
      input  dcache_read, dcache_write, dcache_addr, dcache_wdata,
      input  l2cmem_resp, l2cmem_rdata,
      output icache_resp, icache_rdata, dcache_resp, dcache_rdata,
      output l2cmem_read, l2cmem_write, l2cmem_address, l2cmem_wdata
   );

   modport master (
      output icache_read, icache_addr,
      output dcache_read, dcache_write, dcache_addr, dcache_wdata,
      output l2cmem_resp, l2cmem_rdata,
      input  icache_resp, icache_rdata, dcache_resp, dcache_rdata,
      input  l2cmem_read, l2cmem_write, l2cmem_address, l2cmem_wdata
   );
endinterface

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing l2_cache between the L1 I-cache and D-cache.
// Optional grant counters are enabled with the L2_ARB_STATS_EN macro.
module l2_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
) (
   input  logic              clk,
   input  logic              rst,
   l2_arbiter_if.slave       bus,
   output logic [1:0]        o_state
`ifdef L2_ARB_STATS_EN
   ,
   output logic [31:0]       icache_grant_count,
   output logic [31:0]       dcache_grant_count
`endif
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } state_t;

   state_t                r_state;
   logic                  r_last_d;
   logic                  r_read;
   logic                  r_write;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LINE_WIDTH-1:0] r_wdata;

   logic w_i_req;
   logic w_d_req;
   logic w_pick_d;
   logic w_start;

   assign w_i_req  = bus.icache_read;
   assign w_d_req  = bus.dcache_read | bus.dcache_write;
   // On a tie the port that did not win last time gets the grant.
   assign w_pick_d = w_d_req & (~w_i_req | ~r_last_d);
   assign w_start  = (r_state == IDLE) & (w_i_req | w_d_req);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_last_d <= 1'b0;
         r_read   <= 1'b0;
         r_write  <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  if (w_pick_d) begin
                     // Read+write together is illegal; write takes priority.
                     r_state <= GRANT_D;
                     r_read  <= ~bus.dcache_write;
                     r_write <= bus.dcache_write;
                     r_addr  <= bus.dcache_addr;
                     r_wdata <= bus.dcache_wdata;
                  end else begin
                     r_state <= GRANT_I;
                     r_read  <= 1'b1;
                     r_write <= 1'b0;
                     r_addr  <= bus.icache_addr;
                     r_wdata <= '0;
                  end
               end
            end
            GRANT_I, GRANT_D: begin
               if (bus.l2cmem_resp) begin
                  r_state  <= IDLE;
                  r_read   <= 1'b0;
                  r_write  <= 1'b0;
                  r_last_d <= (r_state == GRANT_D);
               end
            end
            default: begin
               r_state <= IDLE;
               r_read  <= 1'b0;
               r_write <= 1'b0;
            end
         endcase
      end
   end

`ifdef L2_ARB_STATS_EN
   logic [31:0] r_icnt;
   logic [31:0] r_dcnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_icnt <= '0;
         r_dcnt <= '0;
      end else if (w_start) begin
         if (w_pick_d) r_dcnt <= r_dcnt + 32'd1;
         else          r_icnt <= r_icnt + 32'd1;
      end
   end

   assign icache_grant_count = r_icnt;
   assign dcache_grant_count = r_dcnt;
`endif

   assign bus.l2cmem_read    = r_read;
   assign bus.l2cmem_write   = r_write;
   assign bus.l2cmem_address = r_addr;
   assign bus.l2cmem_wdata   = r_wdata;

   assign bus.icache_resp  = (r_state == GRANT_I) & bus.l2cmem_resp;
   assign bus.dcache_resp  = (r_state == GRANT_D) & bus.l2cmem_resp;
   assign bus.icache_rdata = bus.l2cmem_rdata;
   assign bus.dcache_rdata = bus.l2cmem_rdata;

   assign o_state = r_state;

endmodule
